// File: rtl/mod_counter_if.sv
// Control and status bundle for mod_counter: clear/load/enable/direction in,
// registered count and wrap pulse plus boundary flags out.
interface mod_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             at_max;
  logic             at_zero;

  modport master (
    output clear, load, load_val, en, up,
    input  count, wrap, at_max, at_zero
  );

  modport slave (
    input  clear, load, load_val, en, up,
    output count, wrap, at_max, at_zero
  );
endinterface

// File: rtl/mod_counter.sv
// Up/down counter over 0..MAX with clamped load, synchronous clear and a
// wrap/saturate mode; count and wrap come from the same register stage.
module mod_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}},
  parameter bit              SATURATE = 1'b0
) (
  input logic          clk,
  input logic          reset,
  mod_counter_if.slave bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;   // last step was a saturated hold
  logic             up_q;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    // A saturated hold stays "already reported" only while direction is unchanged.
    sat_d   = sat_q && (bus.up == up_q);

    if (bus.clear) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (bus.load) begin
      count_d = (bus.load_val > MAX) ? MAX : bus.load_val;
      sat_d   = 1'b0;
    end else if (bus.en) begin
      if (bus.up) begin
        if (count_q != MAX) begin
          count_d = count_q + WIDTH'(1);
          sat_d   = 1'b0;
        end else if (SATURATE) begin
          wrap_d = ~sat_d;
          sat_d  = 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
          sat_d   = 1'b0;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
          sat_d   = 1'b0;
        end else if (SATURATE) begin
          wrap_d = ~sat_d;
          sat_d  = 1'b1;
        end else begin
          count_d = MAX;
          wrap_d  = 1'b1;
          sat_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
      up_q    <= bus.up;
    end
  end

  assign bus.count   = count_q;
  assign bus.wrap    = wrap_q;
  assign bus.at_max  = (count_q == MAX);
  assign bus.at_zero = (count_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: a wrapping and a saturating instance (MAX=9) share
// the same stimulus and are checked against an integer model each cycle.
module tb_mod_counter;

  localparam logic [3:0] MAXV = 4'd9;

  logic       clk = 1'b0;
  logic       reset, clear, load, en, up;
  logic [3:0] load_val;

  int vectors = 0;
  int fails   = 0;

  // Model state, index 0 = wrap instance, 1 = saturate instance.
  logic [3:0] mc[2];
  bit         mw[2];
  bit         mh[2];
  bit         mlu;

  mod_counter_if #(.WIDTH(4)) if0 ();
  mod_counter_if #(.WIDTH(4)) if1 ();

  assign if0.clear = clear;  assign if1.clear = clear;
  assign if0.load = load;    assign if1.load = load;
  assign if0.load_val = load_val; assign if1.load_val = load_val;
  assign if0.en = en;        assign if1.en = en;
  assign if0.up = up;        assign if1.up = up;

  mod_counter #(.WIDTH(4), .MAX(MAXV), .SATURATE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );
  mod_counter #(.WIDTH(4), .MAX(MAXV), .SATURATE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  logic [3:0] d_cnt[2];
  logic       d_wrap[2], d_max[2], d_zero[2];
  assign d_cnt[0] = if0.count;   assign d_cnt[1] = if1.count;
  assign d_wrap[0] = if0.wrap;   assign d_wrap[1] = if1.wrap;
  assign d_max[0] = if0.at_max;  assign d_max[1] = if1.at_max;
  assign d_zero[0] = if0.at_zero; assign d_zero[1] = if1.at_zero;

  always #5 clk = ~clk;

  // Reference: count lives in 0..MAXV; a saturated hold reports wrap only if
  // the previous cycle was not already such a hold in the same direction.
  task automatic model(input bit r, c, l, input logic [3:0] lv, input bit e, u);
    for (int s = 0; s < 2; s++) begin
      bit same;
      same  = mh[s] && (u == mlu);
      mw[s] = 1'b0;
      if (r || c) begin
        mc[s] = 4'd0; mh[s] = 1'b0;
      end else if (l) begin
        mc[s] = (lv > MAXV) ? MAXV : lv; mh[s] = 1'b0;
      end else if (!e) begin
        mh[s] = same;
      end else if (u) begin
        if (int'(mc[s]) < int'(MAXV)) begin mc[s] = mc[s] + 4'd1; mh[s] = 1'b0; end
        else if (s == 0) begin mc[s] = 4'd0; mw[s] = 1'b1; mh[s] = 1'b0; end
        else begin mw[s] = !same; mh[s] = 1'b1; end
      end else begin
        if (mc[s] > 4'd0) begin mc[s] = mc[s] - 4'd1; mh[s] = 1'b0; end
        else if (s == 0) begin mc[s] = MAXV; mw[s] = 1'b1; mh[s] = 1'b0; end
        else begin mw[s] = !same; mh[s] = 1'b1; end
      end
    end
    mlu = r ? 1'b0 : u;
  endtask

  // Drive one cycle of inputs, advance the model, sample 1ns after the edge.
  task automatic step(input bit r, c, l, input logic [3:0] lv, input bit e, u);
    reset = r; clear = c; load = l; load_val = lv; en = e; up = u;
    @(posedge clk);
    model(r, c, l, lv, e, u);
    #1;
  endtask

  task automatic test_reset;
    step(1, 0, 0, 4'd0, 0, 1);
    step(1, 0, 0, 4'd0, 0, 1);
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if ({d_cnt[s], d_wrap[s], d_max[s], d_zero[s]} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL reset dut%0d: got cnt=%0d wrap=%b max=%b zero=%b, want 0 0 0 1",
                 s, d_cnt[s], d_wrap[s], d_max[s], d_zero[s]);
      end
    end
  endtask

  task automatic test_up_wrap;
    for (int i = 0; i < 12; i++) begin
      logic [3:0] exp;
      step(0, 0, 0, 4'd0, 1, 1);
      exp = 4'((i + 1) % 10);
      vectors++;
      if ({d_cnt[0], d_wrap[0], d_max[0]} !== {exp, exp == 4'd0, exp == MAXV}) begin
        fails++;
        $display("FAIL up_wrap step %0d: got cnt=%0d wrap=%b max=%b, want cnt=%0d", i,
                 d_cnt[0], d_wrap[0], d_max[0], exp);
      end
      for (int s = 0; s < 2; s++) begin
        vectors++;
        if ({d_cnt[s], d_wrap[s], d_max[s], d_zero[s]} !==
            {mc[s], mw[s], mc[s] == MAXV, mc[s] == 4'd0}) begin
          fails++;
          $display("FAIL up_model dut%0d step %0d: got cnt=%0d wrap=%b, want cnt=%0d wrap=%b",
                   s, i, d_cnt[s], d_wrap[s], mc[s], mw[s]);
        end
      end
    end
  endtask

  task automatic test_down;
    logic [3:0] exp_c[5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    bit         exp_w[5] = '{0, 0, 0, 1, 0};
    step(0, 0, 1, 4'd2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step(0, 0, 0, 4'd0, 1, 0);
      vectors++;
      if ({d_cnt[0], d_wrap[0]} !== {exp_c[i], exp_w[i]}) begin
        fails++;
        $display("FAIL down step %0d: got cnt=%0d wrap=%b, want cnt=%0d wrap=%b", i,
                 d_cnt[0], d_wrap[0], exp_c[i], exp_w[i]);
      end
      vectors++;
      if ({d_cnt[1], d_wrap[1]} !== {mc[1], mw[1]}) begin
        fails++;
        $display("FAIL down_sat step %0d: got cnt=%0d wrap=%b, want cnt=%0d wrap=%b", i,
                 d_cnt[1], d_wrap[1], mc[1], mw[1]);
      end
    end
  endtask

  task automatic test_saturate;
    // Steps from 7: 8, 9, then holds; wrap only on the first saturated hold.
    logic [3:0] exp_c[6] = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9, 4'd8};
    bit         exp_w[6] = '{0, 0, 1, 0, 0, 0};
    step(0, 0, 1, 4'd7, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 4'd0, 1, i < 5);
      vectors++;
      if ({d_cnt[1], d_wrap[1], d_max[1]} !== {exp_c[i], exp_w[i], exp_c[i] == MAXV}) begin
        fails++;
        $display("FAIL saturate step %0d: got cnt=%0d wrap=%b max=%b, want cnt=%0d wrap=%b",
                 i, d_cnt[1], d_wrap[1], d_max[1], exp_c[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_priority;
    step(0, 0, 1, 4'd5, 1, 1);
    vectors++;
    if ({d_cnt[0], d_cnt[1], d_wrap[0]} !== {4'd5, 4'd5, 1'b0}) begin
      fails++;
      $display("FAIL load_over_en: got %0d/%0d wrap=%b, want 5/5 wrap=0",
               d_cnt[0], d_cnt[1], d_wrap[0]);
    end
    step(0, 1, 1, 4'd5, 1, 1);
    vectors++;
    if ({d_cnt[0], d_cnt[1]} !== {4'd0, 4'd0}) begin
      fails++;
      $display("FAIL clear_over_load: got %0d/%0d, want 0/0", d_cnt[0], d_cnt[1]);
    end
    step(0, 0, 1, 4'd9, 0, 1);
    step(1, 1, 1, 4'd4, 1, 1);
    vectors++;
    if ({d_cnt[0], d_wrap[0], d_cnt[1], d_wrap[1]} !== {4'd0, 1'b0, 4'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_over_all: got %0d w%b / %0d w%b, want 0 w0 / 0 w0",
               d_cnt[0], d_wrap[0], d_cnt[1], d_wrap[1]);
    end
  endtask

  task automatic test_clamp;
    step(0, 0, 1, 4'd15, 0, 1);
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if ({d_cnt[s], d_max[s], d_wrap[s]} !== {4'd9, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL clamp dut%0d: got cnt=%0d max=%b wrap=%b, want 9 1 0",
                 s, d_cnt[s], d_max[s], d_wrap[s]);
      end
    end
  endtask

  task automatic test_mid_reset;
    step(0, 0, 1, 4'd5, 0, 1);
    step(0, 0, 0, 4'd0, 1, 1);
    vectors++;
    if (d_cnt[0] !== 4'd6) begin
      fails++; $display("FAIL mid_pre: got cnt=%0d, want 6", d_cnt[0]);
    end
    step(1, 0, 0, 4'd0, 1, 1);
    vectors++;
    if ({d_cnt[0], d_wrap[0]} !== {4'd0, 1'b0}) begin
      fails++; $display("FAIL mid_reset: got cnt=%0d wrap=%b, want 0 0", d_cnt[0], d_wrap[0]);
    end
    step(0, 0, 0, 4'd0, 1, 1);
    vectors++;
    if (d_cnt[0] !== 4'd1) begin
      fails++; $display("FAIL mid_resume: got cnt=%0d, want 1", d_cnt[0]);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 4'd0, 0, 1);
      vectors++;
      if ({d_cnt[0], d_wrap[0]} !== {4'd1, 1'b0}) begin
        fails++;
        $display("FAIL hold %0d: got cnt=%0d wrap=%b, want 1 0", i, d_cnt[0], d_wrap[0]);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 6));
      for (int s = 0; s < 2; s++) begin
        vectors++;
        if ({d_cnt[s], d_wrap[s], d_max[s], d_zero[s]} !==
            {mc[s], mw[s], mc[s] == MAXV, mc[s] == 4'd0}) begin
          fails++;
          $display("FAIL random dut%0d cycle %0d: got cnt=%0d wrap=%b max=%b zero=%b, want cnt=%0d wrap=%b",
                   s, i, d_cnt[s], d_wrap[s], d_max[s], d_zero[s], mc[s], mw[s]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; load = 1'b0; load_val = 4'd0; en = 1'b0; up = 1'b1;
    mc[0] = 4'd0; mc[1] = 4'd0; mw[0] = 1'b0; mw[1] = 1'b0; mh[0] = 1'b0; mh[1] = 1'b0;
    mlu = 1'b0;
    test_reset();
    test_up_wrap();
    test_down();
    test_saturate();
    test_priority();
    test_clamp();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
